gps_gga_parser: RTL and testbench
=================================

// Module: gps_gga_parser
// PURPOSE
//  Byte-stream NMEA parser that sits behind the UART receiver. It scans "$GPGGA" sentences and extracts
//  latitude/longitude degree and minute digits as packed ASCII characters. It presents them on
//  data_ready for downstream display/SoC logic. Outputs update atomically once per accepted sentence.
// PARAMETERS
//  (none; field widths fixed by port widths)
// PORTS
//  clk            in   1   system clock; single clock domain
//  rst            in   1   asynchronous, active-low reset
//  uart_data      in   8   received ASCII byte
//  uart_valid     in   1   uart_data valid this cycle; one byte consumed per high cycle
//  latitude_deg   out  16  lat degrees, 2 ASCII chars, first char in [15:8]
//  latitude_min   out  16  lat whole minutes, 2 ASCII chars, first char in [15:8]
//  longitude_deg  out  24  lon degrees, 3 ASCII chars, first char in [23:16]
//  longitude_min  out  16  lon whole minutes, 2 ASCII chars, first char in [15:8]
//  data_ready     out  1   level: a complete fix is held on the position outputs
// BEHAVIOUR
//  - Reset (rst low, async): all outputs 0, FSM=IDLE, shadow registers 0.
//  - Bytes are sampled only on rising clk with uart_valid=1. Idle cycles are ignored. Back-to-back valid is legal.
//  - FSM states: IDLE -> HEADER -> FIELDS -> IDLE.
//    IDLE: wait for '$' (0x24).
//    HEADER: collect 5 chars up to ','.
//    FIELDS: count commas.
//  - '$' in any state: restart. Clear shadow regs and field/char counters, enter HEADER, drop data_ready to 0.
//  - CR (0x0D) or LF (0x0A) before completion: abort to IDLE. Outputs and data_ready are unchanged.
//  - Field index after header: 1=UTC time (ignored), 2=latitude, 3=N/S (ignored), 4=longitude, 5=E/W (ignored).
//  - Latitude field: char0-1 -> shadow lat_deg; char2-3 -> shadow lat_min. Later chars ('.', fraction) are ignored.
//  - Longitude field: char0-2 -> shadow lon_deg; char3-4 -> shadow lon_min. Later chars are ignored.
//  - Char position counter resets at every ','. A short or empty field leaves the missing bytes at 0x00.
//  - Comma terminating field 5 commits: shadow -> outputs and data_ready<=1, visible the cycle after that byte.
//    FSM then returns to IDLE. Subsequent bytes up to the next '$' are ignored.
//  - data_ready stays high, and outputs stay stable, until the next '$' or reset.
//    At the next '$' only data_ready falls; outputs keep their old values until the next commit.
//  - No digit validation: any non-comma byte in a captured position is stored as-is.
// CONFIGURATION
//  GPS_HEADER_CHECK_EN defined:
//    - Header must be exactly "GPGGA" (5 chars, then ',').
//    - On mismatch, go to IDLE; nothing is committed.
//  Undefined:
//    - Any header text up to the first ',' is accepted.
//    - Header length is not checked.
// STRUCTURE
//  Package gps_parser_pkg:
//    - FSM state enum.
//    - ASCII constants: DOLLAR, COMMA, CR, LF, HDR_GPGGA.
//    - Field index constants: F_LAT=2, F_LON=4, F_LAST=5.
//  Single flat module; no sub-module needed.
// TESTING
//  1. Reset; send "$GPGGA,123519,3130,N,1202444,N,".
//     -> data_ready=1, lat_deg=16'h3331, lat_min=16'h3330, lon_deg=24'h313230, lon_min=16'h3234.
//  2. After test 1, send '$'.
//     -> data_ready=0 next cycle; lat_deg still 16'h3331.
//     Then send full sentence with lat 4807, lon 01131 -> new values 16'h3438, 16'h3037, 24'h303131, 16'h3331.
//  3. Send "$GPRMC,123519,3130,N,12024,E,".
//     -> data_ready stays 0 with GPS_HEADER_CHECK_EN; becomes 1 without it.
//  4. Send "$GPGGA,1,31" then '$', then a full valid sentence.
//     -> only the second sentence's values are committed.
//  5. Assert rst low mid-sentence, release, finish the old sentence bytes.
//     -> no commit; all outputs 0.
//  6. Send sentence with empty lat field (",,").
//     -> lat_deg=16'h0000, lat_min=16'h0000; data_ready=1.

Source files
------------

// File: rtl/gps_parser_pkg.sv
// Shared definitions for the NMEA GGA byte-stream parser: FSM states, ASCII
// constants, field indices and the expected sentence header.
package gps_parser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        FIELDS = 2'd2
    } state_t;

    localparam logic [7:0]  DOLLAR    = 8'h24;
    localparam logic [7:0]  COMMA     = 8'h2C;
    localparam logic [7:0]  CR        = 8'h0D;
    localparam logic [7:0]  LF        = 8'h0A;
    localparam logic [39:0] HDR_GPGGA = 40'h4750474741;

    localparam logic [2:0] F_LAT  = 3'd2;
    localparam logic [2:0] F_LON  = 3'd4;
    localparam logic [2:0] F_LAST = 3'd5;

    // Positions past the fifth header character never match any real byte pattern
    // on their own; the caller also rejects them by length.
    function automatic logic [7:0] hdr_char(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = HDR_GPGGA[39:32];
            3'd1:    c = HDR_GPGGA[31:24];
            3'd2:    c = HDR_GPGGA[23:16];
            3'd3:    c = HDR_GPGGA[15:8];
            3'd4:    c = HDR_GPGGA[7:0];
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gps_gga_parser.sv
// NMEA "$GPGGA" parser: captures lat/lon degree and whole-minute ASCII digits and
// commits them atomically. Define GPS_HEADER_CHECK_EN to require the exact "GPGGA" header.
module gps_gga_parser
    import gps_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_data,
    input  logic        uart_valid,
    output logic [15:0] latitude_deg,
    output logic [15:0] latitude_min,
    output logic [23:0] longitude_deg,
    output logic [15:0] longitude_min,
    output logic        data_ready
);

    state_t      state;
    logic [2:0]  field_idx;
    logic [2:0]  char_pos;
    logic [15:0] lat_deg_sh;
    logic [15:0] lat_min_sh;
    logic [23:0] lon_deg_sh;
    logic [15:0] lon_min_sh;
`ifdef GPS_HEADER_CHECK_EN
    logic [2:0]  hdr_cnt;
    logic        hdr_ok;
`endif

    // Shadow registers fill while a sentence streams in; the outputs only change
    // on the comma that closes field 5, so a partial sentence never leaks out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            field_idx     <= 3'd0;
            char_pos      <= 3'd0;
            lat_deg_sh    <= 16'h0;
            lat_min_sh    <= 16'h0;
            lon_deg_sh    <= 24'h0;
            lon_min_sh    <= 16'h0;
            latitude_deg  <= 16'h0;
            latitude_min  <= 16'h0;
            longitude_deg <= 24'h0;
            longitude_min <= 16'h0;
            data_ready    <= 1'b0;
`ifdef GPS_HEADER_CHECK_EN
            hdr_cnt       <= 3'd0;
            hdr_ok        <= 1'b1;
`endif
        end else if (uart_valid) begin
            if (uart_data == DOLLAR) begin
                state      <= HEADER;
                field_idx  <= 3'd0;
                char_pos   <= 3'd0;
                lat_deg_sh <= 16'h0;
                lat_min_sh <= 16'h0;
                lon_deg_sh <= 24'h0;
                lon_min_sh <= 16'h0;
                data_ready <= 1'b0;
`ifdef GPS_HEADER_CHECK_EN
                hdr_cnt    <= 3'd0;
                hdr_ok     <= 1'b1;
`endif
            end else if (uart_data == CR || uart_data == LF) begin
                state <= IDLE;
            end else begin
                case (state)
                    HEADER: begin
                        if (uart_data == COMMA) begin
`ifdef GPS_HEADER_CHECK_EN
                            if (hdr_ok && hdr_cnt == 3'd5) begin
                                state     <= FIELDS;
                                field_idx <= 3'd1;
                                char_pos  <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
`else
                            state     <= FIELDS;
                            field_idx <= 3'd1;
                            char_pos  <= 3'd0;
`endif
                        end
`ifdef GPS_HEADER_CHECK_EN
                        else begin
                            if (hdr_cnt >= 3'd5 || uart_data != hdr_char(hdr_cnt))
                                hdr_ok <= 1'b0;
                            if (hdr_cnt != 3'd7)
                                hdr_cnt <= hdr_cnt + 3'd1;
                        end
`endif
                    end
                    FIELDS: begin
                        if (uart_data == COMMA) begin
                            if (field_idx == F_LAST) begin
                                latitude_deg  <= lat_deg_sh;
                                latitude_min  <= lat_min_sh;
                                longitude_deg <= lon_deg_sh;
                                longitude_min <= lon_min_sh;
                                data_ready    <= 1'b1;
                                state         <= IDLE;
                            end else begin
                                field_idx <= field_idx + 3'd1;
                                char_pos  <= 3'd0;
                            end
                        end else begin
                            // Position saturates so long fractional parts cannot wrap
                            // back into the captured slots.
                            if (char_pos != 3'd7)
                                char_pos <= char_pos + 3'd1;
                            if (field_idx == F_LAT) begin
                                case (char_pos)
                                    3'd0:    lat_deg_sh[15:8] <= uart_data;
                                    3'd1:    lat_deg_sh[7:0]  <= uart_data;
                                    3'd2:    lat_min_sh[15:8] <= uart_data;
                                    3'd3:    lat_min_sh[7:0]  <= uart_data;
                                    default: ;
                                endcase
                            end else if (field_idx == F_LON) begin
                                case (char_pos)
                                    3'd0:    lon_deg_sh[23:16] <= uart_data;
                                    3'd1:    lon_deg_sh[15:8]  <= uart_data;
                                    3'd2:    lon_deg_sh[7:0]   <= uart_data;
                                    3'd3:    lon_min_sh[15:8]  <= uart_data;
                                    3'd4:    lon_min_sh[7:0]   <= uart_data;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gps_gga_parser.sv
// Self-checking bench for gps_gga_parser: a sentence-level reference model
// checked every cycle, plus literal expectations for each directed sentence.
module tb_gps_gga_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        uart_valid = 1'b0;
    logic [15:0] latitude_deg;
    logic [15:0] latitude_min;
    logic [23:0] longitude_deg;
    logic [15:0] longitude_min;
    logic        data_ready;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    // Reference model state: bytes since the last '$', and the committed fix.
    logic [7:0]  sentence[$];
    bit          active = 0;
    logic [15:0] m_lat_deg = 16'h0;
    logic [15:0] m_lat_min = 16'h0;
    logic [23:0] m_lon_deg = 24'h0;
    logic [15:0] m_lon_min = 16'h0;
    logic        m_ready = 1'b0;

    gps_gga_parser dut (
        .clk           (clk),
        .rst           (rst),
        .uart_data     (uart_data),
        .uart_valid    (uart_valid),
        .latitude_deg  (latitude_deg),
        .latitude_min  (latitude_min),
        .longitude_deg (longitude_deg),
        .longitude_min (longitude_min),
        .data_ready    (data_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [23:0] actual, input logic [23:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        sentence.delete();
        active    = 0;
        m_lat_deg = 16'h0;
        m_lat_min = 16'h0;
        m_lon_deg = 24'h0;
        m_lon_min = 16'h0;
        m_ready   = 1'b0;
    endtask

    // Split the buffered sentence into comma-separated fields and take the
    // leading characters of fields 2 and 4; missing characters stay zero.
    task automatic model_commit();
        logic [7:0] lat[4];
        logic [7:0] lon[5];
        logic [7:0] hdr[$];
        int k;
        int p;
        bit hdr_good;
        foreach (lat[i]) lat[i] = 8'h00;
        foreach (lon[i]) lon[i] = 8'h00;
        k = 0;
        p = 0;
        foreach (sentence[i]) begin
            if (sentence[i] == 8'h2C) begin
                k++;
                p = 0;
            end else begin
                if (k == 0) hdr.push_back(sentence[i]);
                if (k == 2 && p < 4) lat[p] = sentence[i];
                if (k == 4 && p < 5) lon[p] = sentence[i];
                p++;
            end
        end
        hdr_good = 1;
`ifdef GPS_HEADER_CHECK_EN
        hdr_good = (hdr.size() == 5) && hdr[0] == "G" && hdr[1] == "P" &&
                   hdr[2] == "G" && hdr[3] == "G" && hdr[4] == "A";
`endif
        if (hdr_good) begin
            m_lat_deg = {lat[0], lat[1]};
            m_lat_min = {lat[2], lat[3]};
            m_lon_deg = {lon[0], lon[1], lon[2]};
            m_lon_min = {lon[3], lon[4]};
            m_ready   = 1'b1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int commas;
        if (b == 8'h24) begin
            sentence.delete();
            active  = 1;
            m_ready = 1'b0;
        end else if (b == 8'h0D || b == 8'h0A) begin
            active = 0;
        end else if (active) begin
            sentence.push_back(b);
            if (b == 8'h2C) begin
                commas = 0;
                foreach (sentence[i]) if (sentence[i] == 8'h2C) commas++;
                if (commas == 6) begin
                    model_commit();
                    active = 0;
                end
            end
        end
    endtask

    // Idle cycles park a '$' on the bus with valid low; it must be ignored.
    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        @(negedge clk);
        uart_data  = b;
        uart_valid = 1'b1;
        @(posedge clk);
        #1;
        model_byte(b);
        if (gap > 0) begin
            @(negedge clk);
            uart_valid = 1'b0;
            uart_data  = 8'h24;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++)
            apply_stimulus(s[i], (i == s.len() - 1) ? 1 : gap);
    endtask

    task automatic expect_fix(input string tag, input logic rdy, input logic [15:0] ld,
                              input logic [15:0] lm, input logic [23:0] od, input logic [15:0] om);
        check_output({tag, "_ready"}, {23'h0, data_ready}, {23'h0, rdy});
        check_output({tag, "_lat_deg"}, {8'h0, latitude_deg}, {8'h0, ld});
        check_output({tag, "_lat_min"}, {8'h0, latitude_min}, {8'h0, lm});
        check_output({tag, "_lon_deg"}, longitude_deg, od);
        check_output({tag, "_lon_min"}, {8'h0, longitude_min}, {8'h0, om});
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check_output("cyc_ready", {23'h0, data_ready}, {23'h0, m_ready});
            check_output("cyc_lat_deg", {8'h0, latitude_deg}, {8'h0, m_lat_deg});
            check_output("cyc_lat_min", {8'h0, latitude_min}, {8'h0, m_lat_min});
            check_output("cyc_lon_deg", longitude_deg, m_lon_deg);
            check_output("cyc_lon_min", {8'h0, longitude_min}, {8'h0, m_lon_min});
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        expect_fix("reset", 1'b0, 16'h0, 16'h0, 24'h0, 16'h0);

        $display("[TB] basic sentence");
        send_str("$GPGGA,123519,3130,N,1202444,N,", 0);
        expect_fix("t1", 1'b1, 16'h3331, 16'h3330, 24'h313230, 16'h3234);
        check_output("t1_model_lat", {8'h0, m_lat_deg}, 24'h003331);

        $display("[TB] restart drops ready only");
        apply_stimulus(8'h24, 0);
        check_output("t2_ready_low", {23'h0, data_ready}, 24'h0);
        check_output("t2_lat_kept", {8'h0, latitude_deg}, 24'h003331);
        send_str("$GPGGA,123519,4807.038,N,01131.000,E,", 2);
        expect_fix("t2", 1'b1, 16'h3438, 16'h3037, 24'h303131, 16'h3331);

        $display("[TB] foreign header");
        send_str("$GPRMC,123519,3130,N,12024,E,", 0);
`ifdef GPS_HEADER_CHECK_EN
        expect_fix("t3", 1'b0, 16'h3438, 16'h3037, 24'h303131, 16'h3331);
`else
        expect_fix("t3", 1'b1, 16'h3331, 16'h3330, 24'h313230, 16'h3234);
`endif

        $display("[TB] restart mid-sentence");
        send_str("$GPGGA,1,31", 0);
        apply_stimulus(8'h24, 0);
        send_str("GPGGA,000000,5512,S,00259,W,", 1);
        expect_fix("t4", 1'b1, 16'h3535, 16'h3132, 24'h303032, 16'h3539);

        $display("[TB] CR abort keeps fix");
        send_str("$GPGGA,1,77", 0);
        apply_stimulus(8'h0D, 0);
        send_str("66,N,12345,E,", 0);
        expect_fix("cr", 1'b0, 16'h3535, 16'h3132, 24'h303032, 16'h3539);

        $display("[TB] trailing bytes after commit ignored");
        send_str("$GPGGA,1,2233,N,44455,E,", 0);
        send_str("9,99,9999,9,99999,9,", 0);
        expect_fix("tail", 1'b1, 16'h3232, 16'h3333, 24'h343434, 16'h3535);

        $display("[TB] reset mid-sentence");
        send_str("$GPGGA,123519,55", 0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        send_str("12,N,00100,E,", 0);
        expect_fix("t5", 1'b0, 16'h0, 16'h0, 24'h0, 16'h0);

        $display("[TB] empty latitude");
        send_str("$GPGGA,1,,N,12345,E,", 0);
        expect_fix("t6", 1'b1, 16'h0000, 16'h0000, 24'h313233, 16'h3435);

        $display("[TB] short longitude");
        send_str("$GPGGA,1,4,N,12,E,", 0);
        expect_fix("short", 1'b1, 16'h3400, 16'h0000, 24'h313200, 16'h0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
